sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single 64-bit SDRAM read port (sdr_addr/sdr_req/sdr_rdy/sdr_data) between several toggle-handshake requesters.
- Requesters include the CPU ROM cache, the sound CPU ROM fetch and the sprite/tile fetchers.
- Selects one pending requester at a time, issues a single-cycle sdr_req and returns the 64-bit line to that requester.
- Re-issues a request if the SDRAM controller does not answer within a timeout.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8).
- ADDR_W, 25, SDRAM byte address width.
- PRIO_PORT, 0, port that wins over round-robin whenever pending.
- PRIO_EN, 1, 1 = PRIO_PORT has absolute priority; 0 = pure round-robin.
- TIMEOUT, 255, WAIT cycles before re-issue (8-bit counter; 0 disables retry).

Ports:
- clk  in  1  system clock; all logic on posedge.
- n_reset  in  1  asynchronous, active-low reset.
- port_req  in  NUM_PORTS  per-port request toggle; port i is pending when port_req[i] != port_ack[i].
- port_addr  in  NUM_PORTS*ADDR_W  per-port address, slice i at [i*ADDR_W +: ADDR_W]; held stable while pending.
- port_ack  out  NUM_PORTS  per-port acknowledge toggle.
- port_data  out  NUM_PORTS*64  per-port returned line, slice i; held until that port's next completion.
- sdr_addr  out  ADDR_W  address to SDRAM controller.
- sdr_req  out  1  single-cycle request strobe.
- sdr_rdy  in  1  data-valid strobe from controller.
- sdr_data  in  64  read data, valid with sdr_rdy.
- busy  out  1  high in WAIT.
- grant  out  3  index of current/last granted port.
- retry_cnt  out  8  saturating count of timeout re-issues since reset.

Behaviour:
- Reset (n_reset low, asynchronous):
  - port_ack=0, port_data=0, sdr_addr=0, sdr_req=0, busy=0, grant=0, retry_cnt=0.
  - Round-robin pointer last=NUM_PORTS-1; state=IDLE; timeout counter=0.
- Reset mid-transaction aborts it without acking. A port whose port_req is 1 when reset is released is pending immediately.
- States: IDLE, WAIT.
- IDLE, no port pending: sdr_req=0.
- IDLE, one or more ports pending, port selection:
  - PRIO_EN=1 and PRIO_PORT pending: PRIO_PORT is selected.
  - Otherwise the first pending port scanning last+1, last+2, ... modulo NUM_PORTS is selected.
- IDLE, at the clock edge after selection:
  - grant<=g, last<=g, sdr_addr<=port_addr[g], sdr_req<=1, timeout counter<=0, state<=WAIT.
  - Capture req_val<=port_req[g].
- WAIT:
  - sdr_req is high only in the first WAIT cycle (1-cycle pulse).
  - sdr_rdy is sampled every WAIT cycle, including the cycle sdr_req is high.
  - On sdr_rdy: port_data[g]<=sdr_data, port_ack[g]<=req_val, state<=IDLE.
  - The completing cycle cannot start a new grant, so there is a minimum of one IDLE cycle between requests.
  - port_ack[g] and port_data[g] update on the same edge.
- Timeout:
  - The counter increments each WAIT cycle without sdr_rdy.
  - When it reaches TIMEOUT (TIMEOUT!=0): sdr_req<=1 again (same sdr_addr), counter<=0, retry_cnt<=retry_cnt+1 saturating at 255.
  - An sdr_rdy in the same cycle as the timeout takes precedence: complete, no re-issue.
- sdr_rdy in IDLE is ignored; no state or output changes.
- Requester rules:
  - A requester toggles port_req only when it is not pending.
  - A toggle while granted is not observed until the current completion. Because ack copies req_val, the port then becomes pending again and is re-served.
- Simultaneous new request on the port being acked: handled by the rule above; no loss.
- busy = (state==WAIT).
- Latency, pending to sdr_req high: 1 clock. sdr_rdy to port_ack: 1 clock.
- Fairness: with PRIO_EN=0 every pending port is granted within NUM_PORTS grants.

Test Plan:
- After reset, toggle port_req[1]=1, port_addr[1]=0x0123450 → next cycle sdr_req=1 for one cycle with sdr_addr=0x0123450, grant=1, busy=1. Return sdr_rdy with sdr_data=0xDEADBEEF_CAFEF00D 3 cycles later → next edge port_ack[1]=1, port_data[1]=0xDEADBEEF_CAFEF00D, busy=0.
- PRIO_EN=0, ports 0, 1, 2 all pending continuously → grant sequence 0,1,2,0,1,2; each port acked once per 3 completions.
- PRIO_EN=1, PRIO_PORT=0; ports 1 and 2 pending; port 0 toggles during port 1's WAIT → grant order 1,0,2.
- TIMEOUT=4, no sdr_rdy → sdr_req re-pulses after 4 WAIT cycles with the same address, retry_cnt=1. Then sdr_rdy → single ack, no further sdr_req.
- Assert n_reset low during WAIT, release, then deliver a stray sdr_rdy → ack and data stay 0, state IDLE. A port with port_req=1 is granted on the first cycle after release.
- sdr_rdy pulses in IDLE with no pending ports → no output change; retry_cnt saturates at 255 under repeated timeouts with TIMEOUT=1.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester toggle-handshake lines and the shared SDRAM read port.
// The master modport is the arbiter's view; slave is the requester/controller side.
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 25
);
    logic [NUM_PORTS-1:0]        port_req;
    logic [NUM_PORTS*ADDR_W-1:0] port_addr;
    logic [NUM_PORTS-1:0]        port_ack;
    logic [NUM_PORTS*64-1:0]     port_data;
    logic [ADDR_W-1:0]           sdr_addr;
    logic                        sdr_req;
    logic                        sdr_rdy;
    logic [63:0]                 sdr_data;
    logic                        busy;
    logic [2:0]                  grant;
    logic [7:0]                  retry_cnt;

    modport master (
        input  port_req, port_addr, sdr_rdy, sdr_data,
        output port_ack, port_data, sdr_addr, sdr_req, busy, grant, retry_cnt
    );

    modport slave (
        output port_req, port_addr, sdr_rdy, sdr_data,
        input  port_ack, port_data, sdr_addr, sdr_req, busy, grant, retry_cnt
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one 64-bit SDRAM read port among toggle-handshake requesters with
// optional fixed-priority port, round-robin fallback and timeout re-issue.
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 25,
    parameter int PRIO_PORT = 0,
    parameter int PRIO_EN   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 n_reset,
    sdram_port_arbiter_if.master bus
);
    localparam logic       RETRY_EN_C = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST_C  = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 state_r;
    logic [NUM_PORTS-1:0]   ack_r;
    logic [63:0]            data_r [NUM_PORTS];
    logic [ADDR_W-1:0]      sdr_addr_r;
    logic                   sdr_req_r;
    logic                   busy_r;
    logic [2:0]             grant_r;
    logic [2:0]             last_r;
    logic [7:0]             retry_r;
    logic [7:0]             cnt_r;
    logic                   req_val_r;

    logic [7:0]             pend8_s;
    logic [7:0]             req8_s;
    logic [ADDR_W-1:0]      addr_arr_s [8];
    logic [3:0]             scan_idx_s;
    logic [2:0]             rr_sel_s;
    logic                   rr_found_s;
    logic [2:0]             sel_s;
    logic                   any_pend_s;

    // Widen per-port vectors to 8 entries so a 3-bit index is always in range
    always_comb begin
        pend8_s = 8'd0;
        req8_s  = 8'd0;
        pend8_s[NUM_PORTS-1:0] = bus.port_req ^ ack_r;
        req8_s[NUM_PORTS-1:0]  = bus.port_req;
        any_pend_s = |pend8_s;
    end

    // Unpack the flat address bus into an indexable array
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            addr_arr_s[i] = '0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr_arr_s[i] = bus.port_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Port selection: priority port first, else first pending after last grant
    always_comb begin
        scan_idx_s = 4'd0;
        rr_sel_s   = 3'd0;
        rr_found_s = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_idx_s = {1'b0, last_r} + 4'(k);
            if (scan_idx_s >= 4'(NUM_PORTS)) begin
                scan_idx_s = scan_idx_s - 4'(NUM_PORTS);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!rr_found_s && pend8_s[scan_idx_s[2:0]]) begin
                rr_sel_s   = scan_idx_s[2:0];
                rr_found_s = 1'b1;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
        if ((PRIO_EN != 0) && pend8_s[PRIO_PORT]) begin
            sel_s = 3'(PRIO_PORT);
        end else begin
            sel_s = rr_sel_s;
        end
    end

    // Arbiter FSM with all outputs registered
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r    <= ST_IDLE;
            ack_r      <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                data_r[i] <= 64'd0;
            end
            sdr_addr_r <= '0;
            sdr_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            grant_r    <= 3'd0;
            last_r     <= 3'(NUM_PORTS - 1);
            retry_r    <= 8'd0;
            cnt_r      <= 8'd0;
            req_val_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_pend_s) begin
                        grant_r    <= sel_s;
                        last_r     <= sel_s;
                        sdr_addr_r <= addr_arr_s[sel_s];
                        sdr_req_r  <= 1'b1;
                        cnt_r      <= 8'd0;
                        req_val_r  <= req8_s[sel_s];
                        busy_r     <= 1'b1;
                        state_r    <= ST_WAIT;
                    end else begin
                        sdr_req_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A completion in the timeout cycle wins over re-issue
                    if (bus.sdr_rdy) begin
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (grant_r == 3'(i)) begin
                                data_r[i] <= bus.sdr_data;
                                ack_r[i]  <= req_val_r;
                            end
                        end
                        sdr_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (RETRY_EN_C && (cnt_r == TO_LAST_C)) begin
                        sdr_req_r <= 1'b1;
                        cnt_r     <= 8'd0;
                        retry_r   <= (retry_r == 8'hFF) ? retry_r : retry_r + 8'd1;
                    end else begin
                        sdr_req_r <= 1'b0;
                        cnt_r     <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    sdr_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_data
        assign bus.port_data[gi*64 +: 64] = data_r[gi];
    end

    assign bus.port_ack  = ack_r;
    assign bus.sdr_addr  = sdr_addr_r;
    assign bus.sdr_req   = sdr_req_r;
    assign bus.busy      = busy_r;
    assign bus.grant     = grant_r;
    assign bus.retry_cnt = retry_r;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: three instances cover priority/timeout,
// pure round-robin, and retry-counter saturation.
module tb_sdram_port_arbiter;
    logic clk;
    logic n_reset;
    int   n_checks;
    int   n_errors;
    int   pulses;

    sdram_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(25)) bus_a ();
    sdram_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(25)) bus_b ();
    sdram_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(25)) bus_c ();

    sdram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(25), .PRIO_PORT(0), .PRIO_EN(1), .TIMEOUT(4))
        dut_a (.clk(clk), .n_reset(n_reset), .bus(bus_a));
    sdram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(25), .PRIO_PORT(0), .PRIO_EN(0), .TIMEOUT(0))
        dut_b (.clk(clk), .n_reset(n_reset), .bus(bus_b));
    sdram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(25), .PRIO_PORT(0), .PRIO_EN(1), .TIMEOUT(1))
        dut_c (.clk(clk), .n_reset(n_reset), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus_a.port_req = '0; bus_a.port_addr = '0; bus_a.sdr_rdy = 1'b0; bus_a.sdr_data = '0;
        bus_b.port_req = '0; bus_b.port_addr = '0; bus_b.sdr_rdy = 1'b0; bus_b.sdr_data = '0;
        bus_c.port_req = '0; bus_c.port_addr = '0; bus_c.sdr_rdy = 1'b0; bus_c.sdr_data = '0;
        n_reset = 1'b1;
        #1 n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;

        // reset state
        check("rst_ack",   64'(bus_a.port_ack), 64'd0);
        check("rst_data",  bus_a.port_data[64 +: 64], 64'd0);
        check("rst_req",   64'(bus_a.sdr_req), 64'd0);
        check("rst_busy",  64'(bus_a.busy), 64'd0);
        check("rst_grant", 64'(bus_a.grant), 64'd0);
        check("rst_retry", 64'(bus_a.retry_cnt), 64'd0);

        // single transaction on port 1
        bus_a.port_addr[25 +: 25] = 25'h0123450;
        bus_a.port_req[1] = 1'b1;
        tick();
        check("t1_req",   64'(bus_a.sdr_req), 64'd1);
        check("t1_addr",  64'(bus_a.sdr_addr), 64'h0123450);
        check("t1_grant", 64'(bus_a.grant), 64'd1);
        check("t1_busy",  64'(bus_a.busy), 64'd1);
        tick();
        check("t1_pulse", 64'(bus_a.sdr_req), 64'd0);
        tick();
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        bus_a.sdr_rdy  = 1'b0;
        check("t1_ack",   64'(bus_a.port_ack), 64'b010);
        check("t1_data",  bus_a.port_data[64 +: 64], 64'hDEADBEEF_CAFEF00D);
        check("t1_busy0", 64'(bus_a.busy), 64'd0);
        check("t1_retry", 64'(bus_a.retry_cnt), 64'd0);

        // priority: ports 1,2 pending, port 0 toggles during port 1's WAIT
        pulse_reset();
        bus_a.port_req = 3'b110;
        tick();
        check("pr_g1", 64'(bus_a.grant), 64'd1);
        bus_a.port_req[0] = 1'b1;
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'h0000_0000_0000_00A1;
        tick();
        bus_a.sdr_rdy = 1'b0;
        check("pr_ack1", 64'(bus_a.port_ack), 64'b010);
        tick();
        check("pr_g0",   64'(bus_a.grant), 64'd0);
        check("pr_req0", 64'(bus_a.sdr_req), 64'd1);
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'h0000_0000_0000_00A0;
        tick();
        bus_a.sdr_rdy = 1'b0;
        check("pr_ack0",  64'(bus_a.port_ack), 64'b011);
        check("pr_data0", bus_a.port_data[0 +: 64], 64'h0000_0000_0000_00A0);
        tick();
        check("pr_g2", 64'(bus_a.grant), 64'd2);
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'h0000_0000_0000_00A2;
        tick();
        bus_a.sdr_rdy = 1'b0;
        check("pr_ack2",  64'(bus_a.port_ack), 64'b111);
        check("pr_data2", bus_a.port_data[128 +: 64], 64'h0000_0000_0000_00A2);

        // timeout re-issue after 4 WAIT cycles
        bus_a.port_addr[25 +: 25] = 25'h1ABCDEF;
        bus_a.port_req[1] = 1'b0;
        tick();
        check("to_req",  64'(bus_a.sdr_req), 64'd1);
        check("to_addr", 64'(bus_a.sdr_addr), 64'h1ABCDEF);
        tick();
        check("to_pulse", 64'(bus_a.sdr_req), 64'd0);
        tick();
        tick();
        check("to_quiet",  64'(bus_a.sdr_req), 64'd0);
        check("to_retry0", 64'(bus_a.retry_cnt), 64'd0);
        tick();
        check("to_rereq",  64'(bus_a.sdr_req), 64'd1);
        check("to_readdr", 64'(bus_a.sdr_addr), 64'h1ABCDEF);
        check("to_retry1", 64'(bus_a.retry_cnt), 64'd1);
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'h5555_AAAA_5555_AAAA;
        tick();
        bus_a.sdr_rdy = 1'b0;
        check("to_ack",  64'(bus_a.port_ack), 64'b101);
        check("to_busy", 64'(bus_a.busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += int'(bus_a.sdr_req);
            tick();
        end
        check("to_noreq", 64'(pulses), 64'd0);
        check("to_ack2",  64'(bus_a.port_ack), 64'b101);

        // reset during WAIT, then stray sdr_rdy
        bus_a.port_req = 3'b001;
        tick();
        check("rw_grant", 64'(bus_a.grant), 64'd2);
        check("rw_busy",  64'(bus_a.busy), 64'd1);
        n_reset = 1'b0;
        #1;
        check("rw_abusy", 64'(bus_a.busy), 64'd0);
        check("rw_aack",  64'(bus_a.port_ack), 64'd0);
        bus_a.port_req = 3'b000;
        tick();
        n_reset = 1'b1;
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        bus_a.sdr_rdy = 1'b0;
        check("rw_sack",  64'(bus_a.port_ack), 64'd0);
        check("rw_sdata", bus_a.port_data[128 +: 64], 64'd0);
        check("rw_sbusy", 64'(bus_a.busy), 64'd0);
        bus_a.port_req = 3'b001;
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
        check("rp_grant", 64'(bus_a.grant), 64'd0);
        check("rp_req",   64'(bus_a.sdr_req), 64'd1);
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'h0123_4567_89AB_CDEF;
        tick();
        bus_a.sdr_rdy = 1'b0;
        check("rp_ack", 64'(bus_a.port_ack), 64'b001);

        // sdr_rdy in IDLE is ignored
        bus_a.sdr_rdy  = 1'b1;
        bus_a.sdr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        bus_a.sdr_rdy = 1'b0;
        check("id_ack",   64'(bus_a.port_ack), 64'b001);
        check("id_data",  bus_a.port_data[0 +: 64], 64'h0123_4567_89AB_CDEF);
        check("id_busy",  64'(bus_a.busy), 64'd0);
        check("id_req",   64'(bus_a.sdr_req), 64'd0);
        check("id_grant", 64'(bus_a.grant), 64'd0);

        // pure round-robin with all ports continuously pending
        bus_b.port_req = 3'b111;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("rr_grant", 64'(bus_b.grant), 64'(n % 3));
            check("rr_req",   64'(bus_b.sdr_req), 64'd1);
            bus_b.sdr_rdy  = 1'b1;
            bus_b.sdr_data = 64'(n + 16);
            tick();
            bus_b.sdr_rdy = 1'b0;
            check("rr_data", bus_b.port_data[(n % 3)*64 +: 64], 64'(n + 16));
            if (n == 2) check("rr_ack3", 64'(bus_b.port_ack), 64'b111);
            if (n == 5) check("rr_ack6", 64'(bus_b.port_ack), 64'b000);
            bus_b.port_req[n % 3] = ~bus_b.port_req[n % 3];
        end

        // retry counter saturation with TIMEOUT=1
        bus_c.port_req[0] = 1'b1;
        tick();
        check("sat_r0", 64'(bus_c.retry_cnt), 64'd0);
        tick();
        check("sat_r1",  64'(bus_c.retry_cnt), 64'd1);
        check("sat_req", 64'(bus_c.sdr_req), 64'd1);
        for (int i = 0; i < 253; i++) tick();
        check("sat_r254", 64'(bus_c.retry_cnt), 64'd254);
        tick();
        check("sat_r255", 64'(bus_c.retry_cnt), 64'd255);
        for (int i = 0; i < 10; i++) tick();
        check("sat_hold", 64'(bus_c.retry_cnt), 64'd255);
        check("sat_busy", 64'(bus_c.busy), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
